// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for a single-port unified memory
// Optional abort-on-timeout is compiled in when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_err,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          dm_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_f,
  output logic          stall_m
);

  if (STARVE_MAX < 1 || TIMEOUT < 2) begin : g_bad_cfg
    $error("mem_arbiter: STARVE_MAX must be >= 1 and TIMEOUT >= 2");
  end

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t        state;
  logic          own_dm;
  logic [SW-1:0] starve_cnt;
  logic          take_dm;

  // Data side wins a contested slot unless fetch has been passed over too often
  assign take_dm = dm_req & (~if_req | (starve_cnt != SW'(STARVE_MAX)));

  assign stall_f = if_req & ~if_done;
  assign stall_m = dm_req & ~dm_done;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  // Abort when the last allowed REQ/WAIT cycle passes without progress
  assign tmo_hit = ((state == REQ && !mem_gnt) || (state == WAIT && !mem_rvalid)) &&
                   (tmo_cnt == TW'(TIMEOUT - 1));

  // Count cycles spent in REQ+WAIT; held at zero while idle so each issue starts fresh
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (state == REQ || state == WAIT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign if_err = 1'b0;
  assign dm_err = 1'b0;
`endif

  // Transaction FSM: arbitrate in IDLE, hold request until grant, wait for response, pulse done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      own_dm     <= 1'b0;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_done    <= 1'b0;
      dm_done    <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      if_err     <= 1'b0;
      dm_err     <= 1'b0;
`endif
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      if_err  <= 1'b0;
      dm_err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            state   <= REQ;
            own_dm  <= take_dm;
            mem_req <= 1'b1;
            if (take_dm) begin
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              if (if_req && starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
            end else begin
              mem_we     <= 1'b0;
              mem_addr   <= if_addr;
              mem_wdata  <= '0;
              starve_cnt <= '0;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            state   <= WAIT;
            mem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state <= RESP;
            if (own_dm) begin
              dm_done  <= 1'b1;
              dm_rdata <= mem_we ? '0 : mem_rdata;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end
        end
        RESP: begin
          state    <= IDLE;
          if_rdata <= '0;
          dm_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
`ifdef MEM_ARB_TIMEOUT_EN
      if (tmo_hit) begin
        state   <= RESP;
        mem_req <= 1'b0;
        if (own_dm) begin
          dm_done  <= 1'b1;
          dm_err   <= 1'b1;
          dm_rdata <= '0;
        end else begin
          if_done  <= 1'b1;
          if_err   <= 1'b1;
          if_rdata <= '0;
        end
      end
`endif
    end
  end

endmodule
